bin2bcd_seq: RTL

Sequential binary-to-BCD converter that sits directly downstream of `fib`. It takes the `N_OUT`-bit `result` and produces packed BCD digits, so the 7-segment decode stage shows decimal instead of hex. It uses a shift-and-add-3 (double dabble) datapath, one bit per clock. It exposes the same 4-phase req/ack handshake as `fib`, so the top level can chain `fib` ack into this block's req.

---
 rtl/fib_pkg.sv | 21 ++
 rtl/bcd_add3.sv | 25 ++
 rtl/bin2bcd_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
//------------------------------------------------------------------------------
// Module   : fib_pkg
// Brief    : Shared types and constants for the fib / bin2bcd_seq pipeline.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fib_pkg;

    localparam int BCD_W = 4;
    localparam int N_OUT = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
//------------------------------------------------------------------------------
// Module   : bcd_add3
// Brief    : Double-dabble digit corrector: adds 3 when the digit is >= 5.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_add3
    import fib_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    // Legal inputs are 0..9, so the result never exceeds 12 and cannot wrap.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_W'(5)) begin
            o_digit = i_digit + BCD_W'(3);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
//------------------------------------------------------------------------------
// Module   : bin2bcd_seq
// Brief    : Bit-serial binary-to-BCD converter with 4-phase req/ack handshake.
//            Optional leading-zero mask enabled by macro BIN2BCD_BLANK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
    import fib_pkg::*;
#(
    parameter int N_IN     = N_OUT,
    parameter int N_DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic [N_IN-1:0]           bin,
    output logic                      ack,
    output logic [BCD_W*N_DIGITS-1:0] bcd,
    output logic                      ovf,
    output logic [N_DIGITS-1:0]       blank
);

    localparam int                 c_bcd_bits = BCD_W * N_DIGITS;
    localparam int                 c_cnt_w    = $clog2(N_IN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N_IN - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_capture;
    logic                    w_shift;
    logic                    w_finish;

    logic [N_IN-1:0]         r_shreg;
    logic [c_bcd_bits-1:0]   r_work;
    logic                    r_ovf_work;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_ack;
    logic [c_bcd_bits-1:0]   r_bcd;
    logic                    r_ovf;

    logic [c_bcd_bits-1:0]   w_work_adj;
    logic [c_bcd_bits-1:0]   w_work_nxt;
    logic                    w_ovf_nxt;

    // FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_shift = 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: per-digit correction, then one-bit left shift of {work, shreg}
    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        bcd_add3 u_add3 (
            .i_digit (r_work[d*BCD_W +: BCD_W]),
            .o_digit (w_work_adj[d*BCD_W +: BCD_W])
        );
    end

    assign w_work_nxt = {w_work_adj[c_bcd_bits-2:0], r_shreg[N_IN-1]};
    assign w_ovf_nxt  = r_ovf_work | w_work_adj[c_bcd_bits-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_work     <= '0;
            r_ovf_work <= 1'b0;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_ack <= (w_state_nxt == S_DONE);
            if (w_capture) begin
                r_shreg    <= bin;
                r_work     <= '0;
                r_ovf_work <= 1'b0;
                r_cnt      <= '0;
            end else if (w_shift) begin
                r_shreg    <= {r_shreg[N_IN-2:0], 1'b0};
                r_work     <= w_work_nxt;
                r_ovf_work <= w_ovf_nxt;
                r_cnt      <= r_cnt + c_cnt_w'(1);
            end
            if (w_finish) begin
                r_bcd <= w_work_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [N_DIGITS-1:0] w_blank;
    logic [N_DIGITS-1:0] r_blank;

    // Walk down from the top digit; digit 0 always stays visible.
    always_comb begin
        logic zero_run;
        w_blank  = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (w_work_nxt[i*BCD_W +: BCD_W] == '0);
            w_blank[i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blank <= '0;
        end else if (w_finish) begin
            r_blank <= w_blank;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

    assign ack = r_ack;
    assign bcd = r_bcd;
    assign ovf = r_ovf;

endmodule

`default_nettype wire
